rx_frame_ctrl: RTL

Sequencer between the demodulator/decoder byte-pair output, the receive register field and the host valid/ready stream. Hunts for a header pair, writes the frame's decoded byte pairs into consecutive register-field addresses, then raises int_rx_host. Drains the stored frame to the host one byte at a time, byte0 then byte1 per address.

---
 rtl/rx_ctrl_pkg.sv | 21 ++
 rtl/rx_timeout_cnt.sv | 36 +++
 rtl/rx_frame_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/rx_ctrl_pkg.sv
// Shared types for the receive frame sequencer: FSM states,
// default header sync byte and the decoded byte-pair bundle.
package rx_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RECV,
      RD,
      CAP,
      B0,
      B1
   } rx_state_e;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   typedef struct packed {
      logic [7:0] byte0;
      logic [7:0] byte1;
   } byte_pair_t;

endpackage

// File: rtl/rx_timeout_cnt.sv
// Idle-cycle watchdog for the payload phase; built only when
// RX_TIMEOUT_EN is defined.
module rx_timeout_cnt #(
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic clr,
   output logic hit
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // hit marks the TIMEOUT_CYC-th consecutive cycle without a pair
   assign hit = run && !clr && (cnt_q == CW'(TIMEOUT_CYC - 1));

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (!run || clr || hit) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/rx_frame_ctrl.sv
// Receive frame sequencer: header hunt, payload store, host drain.
// Optional payload idle timeout under `define RX_TIMEOUT_EN.
module rx_frame_ctrl
   import rx_ctrl_pkg::*;
#(
   parameter int         ADDR_W    = 8,
   parameter int         MAX_PAIRS = 16,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
`ifdef RX_TIMEOUT_EN
   ,
   parameter int         TIMEOUT_CYC = 1024
`endif
) (
   input  logic              G_CLK_RX,
   input  logic              reset,
   input  logic              rx_enable,
   input  logic              dem_valid,
   input  logic [7:0]        dem_byte0,
   input  logic [7:0]        dem_byte1,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_addr,
   output logic [7:0]        rf_wdata0,
   output logic [7:0]        rf_wdata1,
   input  logic [7:0]        rf_rdata0,
   input  logic [7:0]        rf_rdata1,
   output logic              host_valid,
   input  logic              host_ready,
   output logic [7:0]        host_data,
   output logic              int_rx_host,
   output logic              frame_err,
   output logic              overrun,
   output logic              busy
);

   localparam int LW = ADDR_W + 1;

   rx_state_e  state_q, state_d;
   logic [LW-1:0] idx_q, idx_d;
   logic [LW-1:0] len_q, len_d;
   byte_pair_t hold_q, hold_d;
   logic       int_q, int_d;
   logic       err_q, err_d;
   logic       ovr_q, ovr_d;
   logic       busy_q, busy_d;

   logic hdr_hit;
   logic len_ok;
   logic last_idx;
   logic draining;
   logic tmo_hit;

   assign hdr_hit  = dem_valid && rx_enable && (dem_byte0 == SYNC_BYTE);
   // full-width unsigned compare so an oversize length is never wrapped
   assign len_ok   = (dem_byte1 != 8'd0) &&
                     (32'(dem_byte1) <= $unsigned(MAX_PAIRS));
   assign last_idx = (idx_q == len_q - LW'(1));
   assign draining = (state_q == RD) || (state_q == CAP) ||
                     (state_q == B0) || (state_q == B1);

`ifdef RX_TIMEOUT_EN
   rx_timeout_cnt #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_tmo (
      .clk  (G_CLK_RX),
      .reset(reset),
      .run  (state_q == RECV),
      .clr  (dem_valid),
      .hit  (tmo_hit)
   );
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      hold_d  = hold_q;
      int_d   = int_q;
      err_d   = 1'b0;
      ovr_d   = ovr_q;
      unique case (state_q)
         IDLE: begin
            if (hdr_hit) begin
               if (len_ok) begin
                  len_d   = LW'(dem_byte1);
                  idx_d   = '0;
                  state_d = RECV;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         RECV: begin
            if (dem_valid) begin
               if (last_idx) begin
                  idx_d   = '0;
                  int_d   = 1'b1;
                  state_d = RD;
               end else begin
                  idx_d = idx_q + LW'(1);
               end
            end else if (tmo_hit) begin
               err_d   = 1'b1;
               idx_d   = '0;
               state_d = IDLE;
            end
         end
         RD: begin
            state_d = CAP;
         end
         CAP: begin
            hold_d.byte0 = rf_rdata0;
            hold_d.byte1 = rf_rdata1;
            state_d      = B0;
         end
         B0: begin
            if (host_ready) begin
               state_d = B1;
            end
         end
         B1: begin
            if (host_ready) begin
               if (last_idx) begin
                  idx_d   = '0;
                  int_d   = 1'b0;
                  state_d = IDLE;
               end else begin
                  idx_d   = idx_q + LW'(1);
                  state_d = RD;
               end
            end
         end
         default: begin
            idx_d   = '0;
            int_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
      if (dem_valid && draining) begin
         ovr_d = 1'b1;
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge G_CLK_RX) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         hold_q  <= '0;
         int_q   <= 1'b0;
         err_q   <= 1'b0;
         ovr_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         hold_q  <= hold_d;
         int_q   <= int_d;
         err_q   <= err_d;
         ovr_q   <= ovr_d;
         busy_q  <= busy_d;
      end
   end

   // payload writes go out in the same cycle the pair arrives
   assign rf_we     = (state_q == RECV) && dem_valid;
   assign rf_addr   = idx_q[ADDR_W-1:0];
   assign rf_wdata0 = rf_we ? dem_byte0 : 8'd0;
   assign rf_wdata1 = rf_we ? dem_byte1 : 8'd0;

   assign host_valid = (state_q == B0) || (state_q == B1);
   assign host_data  = (state_q == B0) ? hold_q.byte0 :
                       (state_q == B1) ? hold_q.byte1 : 8'd0;

   assign int_rx_host = int_q;
   assign frame_err   = err_q;
   assign overrun     = ovr_q;
   assign busy        = busy_q;

endmodule
